// File: rtl/wb_pkg.sv
// Shared Wishbone host definitions: bus widths, FSM state encoding and a
// helper for sizing the bus timeout counter.
package wb_pkg;

  localparam int unsigned WB_ADR_W = 32;
  localparam int unsigned WB_DAT_W = 32;
  localparam int unsigned WB_SEL_W = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBus  = 2'd1,
    StResp = 2'd2
  } wb_state_e;

  // Width needed to count 0..limit, never narrower than one bit.
  function automatic int unsigned ctr_width(int unsigned limit);
    int unsigned w;
    w = $clog2(limit + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/wbm_timeout_ctr.sv
// Bus-cycle counter for the Wishbone host: cleared when a transfer starts,
// counts every cycle the bus is held, flags expiry on the last allowed cycle.
module wbm_timeout_ctr
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned   CntW      = ctr_width(TIMEOUT_CYCLES);
  localparam bit            TimeoutEn = (TIMEOUT_CYCLES != 0);
  localparam logic [CntW-1:0] Limit   = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] count_q, count_d;

  // Expiry only exists when a non-zero limit is configured.
  assign expired_o = TimeoutEn && (count_q == Limit);

  // Next count: clear wins; increment stops at the limit so it never wraps.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && TimeoutEn && !expired_o) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wb_host_initiator.sv
// Wishbone classic single-transfer initiator. Turns a valid/ready command into
// one registered Wishbone read or write and returns a valid/ready response,
// reporting an error if the slave does not acknowledge in time.
module wb_host_initiator
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [WB_ADR_W-1:0] cmd_adr,
  input  logic [WB_DAT_W-1:0] cmd_dat,
  input  logic [WB_SEL_W-1:0] cmd_sel,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WB_DAT_W-1:0] rsp_dat,
  output logic                rsp_err,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [WB_SEL_W-1:0] wbm_sel_o,
  output logic [WB_ADR_W-1:0] wbm_adr_o,
  output logic [WB_DAT_W-1:0] wbm_dat_o,
  input  logic                wbm_ack_i,
  input  logic [WB_DAT_W-1:0] wbm_dat_i
);

  wb_state_e           state_q, state_d;
  logic                cyc_d, stb_d, we_d;
  logic [WB_SEL_W-1:0] sel_d;
  logic [WB_ADR_W-1:0] adr_d;
  logic [WB_DAT_W-1:0] dat_d;
  logic                rsp_valid_d, rsp_err_d;
  logic [WB_DAT_W-1:0] rsp_dat_d;
  logic                ctr_clear, ctr_enable, ctr_expired;

  // Reset is folded in so no command can be accepted while it is asserted.
  assign cmd_ready = (state_q == StIdle) & ~wb_rst_i;

  wbm_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .clear_i  (ctr_clear),
    .enable_i (ctr_enable),
    .expired_o(ctr_expired)
  );

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_d     = state_q;
    cyc_d       = wbm_cyc_o;
    stb_d       = wbm_stb_o;
    we_d        = wbm_we_o;
    sel_d       = wbm_sel_o;
    adr_d       = wbm_adr_o;
    dat_d       = wbm_dat_o;
    rsp_valid_d = rsp_valid;
    rsp_dat_d   = rsp_dat;
    rsp_err_d   = rsp_err;
    ctr_clear   = 1'b0;
    ctr_enable  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          we_d      = cmd_we;
          adr_d     = cmd_adr;
          dat_d     = cmd_dat;
          sel_d     = cmd_sel;
          cyc_d     = 1'b1;
          stb_d     = 1'b1;
          ctr_clear = 1'b1;
          state_d   = StBus;
        end
      end
      StBus: begin
        ctr_enable = 1'b1;
        // Ack takes priority over a coincident timeout.
        if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_dat_d   = wbm_we_o ? '0 : wbm_dat_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else if (ctr_expired) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end
      end
      StResp: begin
        // rsp_dat/rsp_err keep their values after the handshake.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; reset drops the bus asynchronously.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wbm_cyc_o <= cyc_d;
      wbm_stb_o <= stb_d;
      wbm_we_o  <= we_d;
      wbm_sel_o <= sel_d;
      wbm_adr_o <= adr_d;
      wbm_dat_o <= dat_d;
      rsp_valid <= rsp_valid_d;
      rsp_dat   <= rsp_dat_d;
      rsp_err   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_wb_host_initiator.sv
// Scoreboard bench for wb_host_initiator: the driver pushes the expected
// transfer/response from a reference model; a monitor checks the bus and
// response channels against the queue.
module tb_wb_host_initiator;

  localparam int unsigned TO = 8;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0;
  logic [31:0] cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic        wbm_ack_i = 1'b0;
  logic [31:0] wbm_dat_i = '0;

  wb_host_initiator #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),
    .cmd_sel  (cmd_sel),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o (wbm_we_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i),
    .wbm_dat_i(wbm_dat_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int cyc_cnt = 0;
  always @(posedge wb_clk_i) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp_dat;
    logic        exp_err;
    int          acc;   // cycle count just after the accepting edge
    int          bus;   // expected number of cycles with cyc/stb high
  } txn_t;

  txn_t        sb[$];
  logic [31:0] ref_mem[logic [29:0]];
  logic [31:0] slv_mem[logic [29:0]];
  int          vectors = 0;
  int          fails = 0;
  int          hs_cycle = 0;
  int          sl_delay = 0;
  bit          sl_noack = 0;
  bit          sl_stray = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Slave: acks after sl_delay wait cycles, optionally never acks, and can
  // throw stray acks while no cycle is open.
  initial begin
    int waited;
    waited = 0;
    forever begin
      @(negedge wb_clk_i);
      if (wb_rst_i || !wbm_cyc_o || !wbm_stb_o) begin
        waited    = 0;
        wbm_ack_i = sl_stray ? 1'($urandom_range(0, 1)) : 1'b0;
        wbm_dat_i = $urandom;
      end else if (!sl_noack && waited == sl_delay) begin
        wbm_ack_i = 1'b1;
        waited++;
        if (wbm_we_o) begin
          logic [31:0] w;
          w = slv_mem.exists(wbm_adr_o[31:2]) ? slv_mem[wbm_adr_o[31:2]] : 32'h0;
          for (int b = 0; b < 4; b++)
            if (wbm_sel_o[b]) w[8*b +: 8] = wbm_dat_o[8*b +: 8];
          slv_mem[wbm_adr_o[31:2]] = w;
          wbm_dat_i = $urandom;
        end else begin
          wbm_dat_i = slv_mem.exists(wbm_adr_o[31:2]) ? slv_mem[wbm_adr_o[31:2]] : 32'h0;
        end
      end else begin
        wbm_ack_i = 1'b0;
        waited++;
      end
    end
  end

  // Monitor: bus-side checks against the newest entry, response checks
  // against the oldest; pops on the response handshake.
  initial begin
    int          bus_cnt;
    logic        prev_cyc, shown, have_last;
    logic [31:0] last_adr;
    txn_t        cur;
    bus_cnt = 0; prev_cyc = 0; shown = 0; have_last = 0; last_adr = '0;
    forever begin
      @(negedge wb_clk_i);
      if (wb_rst_i) begin
        bus_cnt = 0; prev_cyc = 0; shown = 0; have_last = 0;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_cyc_stb", {wbm_cyc_o, wbm_stb_o}, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_adr", wbm_adr_o, 0);
        continue;
      end
      if (wbm_cyc_o || wbm_stb_o) begin
        if (sb.size() == 0) begin
          check("stray_cyc", wbm_cyc_o, 0);
        end else begin
          cur = sb[sb.size()-1];
          bus_cnt++;
          check("bus_cyc_stb", {wbm_cyc_o, wbm_stb_o}, 2'b11);
          check("bus_adr", wbm_adr_o, cur.adr);
          check("bus_we", wbm_we_o, cur.we);
          check("bus_sel", wbm_sel_o, cur.sel);
          if (cur.we) check("bus_dat", wbm_dat_o, cur.dat);
          check("bus_cmd_ready", cmd_ready, 0);
        end
      end else if (prev_cyc) begin
        check("bus_cycles", bus_cnt, cur.bus);
        bus_cnt   = 0;
        have_last = 1;
        last_adr  = cur.adr;
      end else if (have_last) begin
        check("adr_hold", wbm_adr_o, last_adr);
      end
      prev_cyc = wbm_cyc_o;

      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("stray_rsp_valid", rsp_valid, 0);
        end else begin
          if (!shown) check("rsp_latency", cyc_cnt - sb[0].acc, sb[0].bus);
          check("rsp_dat", rsp_dat, sb[0].exp_dat);
          check("rsp_err", rsp_err, sb[0].exp_err);
          check("rsp_cmd_ready", cmd_ready, 0);
          if (rsp_ready) begin
            void'(sb.pop_front());
            hs_cycle = cyc_cnt + 1;
            shown    = 0;
          end else begin
            shown = 1;
          end
        end
      end
    end
  end

  // Presents a command (valid stays high on return) and queues its expected
  // outcome from the reference store and the slave's configured behaviour.
  task automatic send(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output int acc);
    txn_t        t;
    bit          ok;
    logic [31:0] w;
    ok  = 0;
    acc = -1;
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge wb_clk_i);
      if (cmd_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      check("cmd_accept", cmd_ready, 1);
      return;
    end
    @(posedge wb_clk_i);
    #1;
    acc = cyc_cnt;
    t.we = we; t.adr = adr; t.dat = dat; t.sel = sel; t.acc = acc;
    if (sl_noack || sl_delay >= int'(TO)) begin
      t.exp_err = 1'b1; t.exp_dat = '0; t.bus = TO;
    end else begin
      t.exp_err = 1'b0;
      t.bus     = sl_delay + 1;
      w = ref_mem.exists(adr[31:2]) ? ref_mem[adr[31:2]] : 32'h0;
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (sel[b]) w[8*b +: 8] = dat[8*b +: 8];
        ref_mem[adr[31:2]] = w;
        t.exp_dat = '0;
      end else begin
        t.exp_dat = w;
      end
    end
    sb.push_back(t);
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge wb_clk_i);
      #1;
      if (sb.size() == 0 && !rsp_valid && !wbm_cyc_o) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("drain_pending", sb.size(), 0);
  endtask

  task automatic wait_rsp();
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge wb_clk_i);
      if (rsp_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("rsp_arrival", rsp_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d of %0d compares bad", fails, vectors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, prev_acc;
    repeat (2) @(negedge wb_clk_i);
    @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;

    // Zero-wait write.
    send(1'b1, 32'h3000_0004, 32'hA5A5_0001, 4'hF, acc);
    cmd_valid = 1'b0;
    drain();

    // Read with 3 wait states, then the ack-versus-timeout boundary.
    slv_mem[30'h0C00_0002] = 32'h1234_5678;
    ref_mem[30'h0C00_0002] = 32'h1234_5678;
    for (int d = 3; d <= 7; d += 2) begin
      sl_delay = (d == 5) ? 6 : d;
      send(1'b0, 32'h3000_0008, $urandom, 4'hF, acc);
      cmd_valid = 1'b0;
      drain();
    end

    // Timeout with the response held off for a few cycles.
    sl_noack  = 1;
    rsp_ready = 1'b0;
    send(1'b0, 32'h3000_000C, 32'h0, 4'hF, acc);
    cmd_valid = 1'b0;
    wait_rsp();
    repeat (3) @(negedge wb_clk_i) check("to_cmd_ready", cmd_ready, 0);
    @(posedge wb_clk_i);
    #1 rsp_ready = 1'b1;
    drain();

    // Back-pressured response with the next command already waiting.
    sl_noack  = 0;
    sl_delay  = 1;
    rsp_ready = 1'b0;
    send(1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'h3, acc);
    cmd_we = 1'b0;
    wait_rsp();
    repeat (5) @(negedge wb_clk_i) check("bp_cmd_ready", cmd_ready, 0);
    @(posedge wb_clk_i);
    #1 rsp_ready = 1'b1;
    send(1'b0, 32'h3000_0010, 32'h0, 4'hF, acc);
    cmd_valid = 1'b0;
    check("bp_accept_after_hs", acc, hs_cycle + 1);
    drain();

    // Asynchronous reset in the second cycle of a stalled read.
    sl_noack = 1;
    send(1'b0, 32'h3000_0014, 32'h0, 4'hF, acc);
    cmd_valid = 1'b0;
    @(posedge wb_clk_i);
    #2 wb_rst_i = 1'b1;
    #1;
    check("async_rst_cyc", wbm_cyc_o, 0);
    check("async_rst_stb", wbm_stb_o, 0);
    sb.delete();
    sl_noack = 0;
    @(posedge wb_clk_i);
    #2 wb_rst_i = 1'b0;
    repeat (4) @(negedge wb_clk_i) check("post_rst_no_rsp", rsp_valid, 0);
    @(posedge wb_clk_i);
    #1;
    sl_delay = 0;
    send(1'b1, 32'h3000_0018, $urandom, 4'hF, acc);
    cmd_valid = 1'b0;
    drain();

    // Back-to-back random traffic with stray acks between transfers.
    sl_stray = 1;
    prev_acc = 0;
    for (int i = 0; i < 16; i++) begin
      send(1'($urandom_range(0, 1)), 32'h3000_0000 + ($urandom_range(0, 7) << 2), $urandom,
           4'($urandom_range(0, 15)), acc);
      if (i > 0) check("b2b_spacing", acc - prev_acc, 3);
      prev_acc = acc;
    end
    cmd_valid = 1'b0;
    sl_stray  = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
